// File: rtl/lcd_time_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_time_pkg
// Description : Shared widths, BCD limits and helper functions for the LCD
//               time-of-day counter.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_time_pkg;

    localparam int DIGIT_W = 4;
    localparam int FIELD_W = 8;

    localparam logic [FIELD_W-1:0] SEC_MAX   = 8'h59;
    localparam logic [FIELD_W-1:0] MIN_MAX   = 8'h59;
    localparam logic [FIELD_W-1:0] HR_MAX_24 = 8'h23;

    // True when both nibbles are decimal digits and the field does not exceed
    // max. With legal digits, plain unsigned compare orders BCD correctly.
    function automatic logic bcd_in_range(input logic [FIELD_W-1:0] f,
                                          input logic [FIELD_W-1:0] max);
        return (f[DIGIT_W-1:0] <= 4'd9) && (f[FIELD_W-1:DIGIT_W] <= 4'd9) && (f <= max);
    endfunction

    // Maps a 24-hour BCD hour onto the 12-hour face: 00 -> 12, 13..23 -> 01..11.
    function automatic logic [FIELD_W-1:0] bcd_to_12h(input logic [FIELD_W-1:0] hh24);
        logic [4:0] h;
        h = 5'(hh24[FIELD_W-1:DIGIT_W]) * 5'd10 + 5'(hh24[DIGIT_W-1:0]);
        if (h == 5'd0) begin
            h = 5'd12;
        end else if (h > 5'd12) begin
            h = h - 5'd12;
        end
        return {4'(h / 5'd10), 4'(h % 5'd10)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_time_counter_bcd_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_mod_counter
// Description : Two-digit packed-BCD counter wrapping at MAX_VAL, with
//               increment, parallel load and carry-out on wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_mod_counter
    import lcd_time_pkg::*;
#(
    parameter logic [7:0] MAX_VAL = 8'h59
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_inc,
    input  logic               i_load,
    input  logic [FIELD_W-1:0] i_load_val,
    output logic [FIELD_W-1:0] o_q,
    output logic [FIELD_W-1:0] o_next,
    output logic               o_carry
);

    logic [FIELD_W-1:0] r_q;
    logic [FIELD_W-1:0] w_next;

    // Next value: load has priority; increment carries units into tens.
    always_comb begin
        w_next = r_q;
        if (i_load) begin
            w_next = i_load_val;
        end else if (i_inc) begin
            if (r_q == MAX_VAL) begin
                w_next = '0;
            end else if (r_q[DIGIT_W-1:0] == 4'd9) begin
                w_next = {r_q[FIELD_W-1:DIGIT_W] + 4'd1, 4'd0};
            end else begin
                w_next = {r_q[FIELD_W-1:DIGIT_W], r_q[DIGIT_W-1:0] + 4'd1};
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_next;
        end
    end

    assign o_q     = r_q;
    assign o_next  = w_next;
    assign o_carry = i_inc & ~i_load & (r_q == MAX_VAL);

endmodule
`default_nettype wire

// File: rtl/lcd_time_counter.sv
`default_nettype none
// ============================================================================
// Module      : lcd_time_counter
// Description : HH:MM:SS packed-BCD time-of-day counter advanced by rising
//               edges of a synchronized slow square wave, with a set-time
//               load handshake and registered display outputs.
//               Optional macro LCD_12H_EN selects a 12-hour display face.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_time_counter
    import lcd_time_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOUR_MAX    = 23
) (
    input  logic               clock_in,
    input  logic               reset,
    input  logic               slow_clk,
    input  logic               run,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [FIELD_W-1:0] load_hh,
    input  logic [FIELD_W-1:0] load_mm,
    input  logic [FIELD_W-1:0] load_ss,
    output logic               load_err,
    output logic [FIELD_W-1:0] hr_bcd,
    output logic [FIELD_W-1:0] min_bcd,
    output logic [FIELD_W-1:0] sec_bcd,
    output logic               pm_flag,
    output logic               upd_strobe,
    output logic               day_wrap
);

    localparam logic [FIELD_W-1:0] c_HR_MAX_BCD = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_load_ready;
    logic                   r_upd;
    logic                   r_err;
    logic                   r_wrap;
    logic [FIELD_W-1:0]     r_hr_disp;

    logic w_tick, w_tick_soon, w_inc, w_xfer, w_load_ok, w_load;
    logic w_sec_carry, w_min_carry, w_hr_carry;
    logic [FIELD_W-1:0] w_sec_q, w_min_q, w_hr_q;
    logic [FIELD_W-1:0] w_sec_next, w_min_next, w_hr_next;

    // Synchronizer chain and edge register tracking slow_clk regardless of run.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], slow_clk};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_tick      = r_sync[SYNC_STAGES-1] & ~r_prev;
    // w_tick as it will be next cycle, so load_ready can be a register.
    assign w_tick_soon = r_sync[SYNC_STAGES-2] & ~r_sync[SYNC_STAGES-1];
    assign w_inc       = w_tick & run;

    assign w_xfer    = load_valid & r_load_ready;
    assign w_load_ok = bcd_in_range(load_hh, c_HR_MAX_BCD) &
                       bcd_in_range(load_mm, MIN_MAX) &
                       bcd_in_range(load_ss, SEC_MAX);
    assign w_load    = w_xfer & w_load_ok;

    bcd_mod_counter #(.MAX_VAL(SEC_MAX)) u_sec (
        .clk        (clock_in),
        .rst        (reset),
        .i_inc      (w_inc),
        .i_load     (w_load),
        .i_load_val (load_ss),
        .o_q        (w_sec_q),
        .o_next     (w_sec_next),
        .o_carry    (w_sec_carry)
    );

    bcd_mod_counter #(.MAX_VAL(MIN_MAX)) u_min (
        .clk        (clock_in),
        .rst        (reset),
        .i_inc      (w_sec_carry),
        .i_load     (w_load),
        .i_load_val (load_mm),
        .o_q        (w_min_q),
        .o_next     (w_min_next),
        .o_carry    (w_min_carry)
    );

    bcd_mod_counter #(.MAX_VAL(c_HR_MAX_BCD)) u_hr (
        .clk        (clock_in),
        .rst        (reset),
        .i_inc      (w_min_carry),
        .i_load     (w_load),
        .i_load_val (load_hh),
        .o_q        (w_hr_q),
        .o_next     (w_hr_next),
        .o_carry    (w_hr_carry)
    );

    // Handshake and pulse outputs, all registered alongside the count.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_load_ready <= 1'b0;
            r_upd        <= 1'b0;
            r_err        <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            r_load_ready <= ~w_tick_soon;
            r_upd        <= w_inc | w_load;
            r_err        <= w_xfer & ~w_load_ok;
            r_wrap       <= w_hr_carry;
        end
    end

`ifdef LCD_12H_EN
    logic r_pm;

    // 12-hour face registered from the next hour so it changes with the count.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_hr_disp <= 8'h12;
            r_pm      <= 1'b0;
        end else begin
            r_hr_disp <= bcd_to_12h(w_hr_next);
            r_pm      <= (w_hr_next >= 8'h12);
        end
    end

    assign pm_flag = r_pm;
`else
    // 24-hour face: the displayed hour is the internal hour.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_hr_disp <= '0;
        end else begin
            r_hr_disp <= w_hr_next;
        end
    end

    assign pm_flag = 1'b0;
`endif

    // Counter taps not needed for the outputs.
    logic w_unused;
    assign w_unused = ^{w_sec_next, w_min_next, w_hr_q};

    assign load_ready = r_load_ready;
    assign load_err   = r_err;
    assign upd_strobe = r_upd;
    assign day_wrap   = r_wrap;
    assign hr_bcd     = r_hr_disp;
    assign min_bcd    = w_min_q;
    assign sec_bcd    = w_sec_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_time_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_time_counter
// Description : Scoreboard bench for lcd_time_counter. Stimulus pushes the
//               expected time after each counted tick or valid load; a
//               monitor pops and compares on every upd_strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_time_counter;

    logic       clock_in = 1'b0;
    logic       reset, slow_clk, run, load_valid;
    logic [7:0] load_hh, load_mm, load_ss;
    logic       load_ready, load_err, pm_flag, upd_strobe, day_wrap;
    logic [7:0] hr_bcd, min_bcd, sec_bcd;

    lcd_time_counter #(.SYNC_STAGES(2), .HOUR_MAX(23)) dut (
        .clock_in   (clock_in),
        .reset      (reset),
        .slow_clk   (slow_clk),
        .run        (run),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_hh    (load_hh),
        .load_mm    (load_mm),
        .load_ss    (load_ss),
        .load_err   (load_err),
        .hr_bcd     (hr_bcd),
        .min_bcd    (min_bcd),
        .sec_bcd    (sec_bcd),
        .pm_flag    (pm_flag),
        .upd_strobe (upd_strobe),
        .day_wrap   (day_wrap)
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        int h;
        int m;
        int s;
        bit wrap;
    } exp_t;

    exp_t q_exp[$];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   exp_err = 0;
    int   n_upd   = 0;
    int   m_h = 0, m_m = 0, m_s = 0;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int from_bcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] disp_hr(input int h);
`ifdef LCD_12H_EN
        if (h == 0) return to_bcd(12);
        if (h > 12) return to_bcd(h - 12);
        return to_bcd(h);
`else
        return to_bcd(h);
`endif
    endfunction

    function automatic logic disp_pm(input int h);
`ifdef LCD_12H_EN
        return (h >= 12);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every update must match the oldest outstanding expectation.
    always @(negedge clock_in) begin
        if (!reset) begin
            if (upd_strobe) begin
                n_upd++;
                if (q_exp.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_upd: got %0h:%0h:%0h expected no update",
                             hr_bcd, min_bcd, sec_bcd);
                end else begin
                    exp_t e;
                    e = q_exp.pop_front();
                    check("upd_hr",   {24'd0, hr_bcd},  {24'd0, disp_hr(e.h)});
                    check("upd_min",  {24'd0, min_bcd}, {24'd0, to_bcd(e.m)});
                    check("upd_sec",  {24'd0, sec_bcd}, {24'd0, to_bcd(e.s)});
                    check("upd_pm",   {31'd0, pm_flag}, {31'd0, disp_pm(e.h)});
                    check("upd_wrap", {31'd0, day_wrap}, {31'd0, e.wrap});
                end
            end else if (day_wrap) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stray_wrap: got 1 expected 0");
            end
            if (load_err) begin
                n_cmp++;
                if (exp_err > 0) begin
                    exp_err--;
                end else begin
                    n_bad++;
                    $display("FAIL unexpected_err: got 1 expected 0");
                end
            end
        end
    end

    task automatic push_tick();
        exp_t e;
        e.wrap = 1'b0;
        m_s++;
        if (m_s == 60) begin
            m_s = 0;
            m_m++;
            if (m_m == 60) begin
                m_m = 0;
                m_h++;
                if (m_h == 24) begin
                    m_h    = 0;
                    e.wrap = 1'b1;
                end
            end
        end
        e.h = m_h; e.m = m_m; e.s = m_s;
        q_exp.push_back(e);
    endtask

    task automatic slow_pulse(input bit counted);
        if (counted) push_tick();
        @(negedge clock_in) slow_clk = 1'b1;
        repeat (5) @(negedge clock_in);
        slow_clk = 1'b0;
        repeat (5) @(negedge clock_in);
    endtask

    // One pulse with the latency checked: new seconds on the 3rd edge exactly.
    task automatic timed_tick();
        logic [7:0] old;
        push_tick();
        @(negedge clock_in) slow_clk = 1'b1;
        old = sec_bcd;
        @(posedge clock_in);
        @(posedge clock_in);
        #1 check("sec_before_3rd_edge", {24'd0, sec_bcd}, {24'd0, old});
        @(posedge clock_in);
        #1 check("sec_on_3rd_edge", {24'd0, sec_bcd}, {24'd0, to_bcd(m_s)});
        repeat (4) @(negedge clock_in);
        slow_clk = 1'b0;
        repeat (5) @(negedge clock_in);
    endtask

    // Caller is at a negedge. Expectation is recorded before the transfer.
    task automatic do_load(input logic [7:0] hh, input logic [7:0] mm,
                           input logic [7:0] ss, input bit ok);
        bit done;
        if (ok) begin
            exp_t e;
            m_h = from_bcd(hh); m_m = from_bcd(mm); m_s = from_bcd(ss);
            e.h = m_h; e.m = m_m; e.s = m_s; e.wrap = 1'b0;
            q_exp.push_back(e);
        end else begin
            exp_err++;
        end
        load_hh = hh; load_mm = mm; load_ss = ss;
        load_valid = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (load_ready) begin
                done = 1'b1;
                break;
            end
            @(negedge clock_in);
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL load_ready_timeout: got 0 expected 1");
        end
        @(posedge clock_in);
        @(negedge clock_in) load_valid = 1'b0;
    endtask

    task automatic check_count(input string name);
        check({name, "_hr"},  {24'd0, hr_bcd},  {24'd0, disp_hr(m_h)});
        check({name, "_min"}, {24'd0, min_bcd}, {24'd0, to_bcd(m_m)});
        check({name, "_sec"}, {24'd0, sec_bcd}, {24'd0, to_bcd(m_s)});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; slow_clk = 1'b0; run = 1'b1; load_valid = 1'b0;
        load_hh = 8'h00; load_mm = 8'h00; load_ss = 8'h00;
        repeat (3) @(negedge clock_in);
        check_count("reset");
        check("reset_pm",    {31'd0, pm_flag},    32'd0);
        check("reset_ready", {31'd0, load_ready}, 32'd0);
        check("reset_upd",   {31'd0, upd_strobe}, 32'd0);
        check("reset_wrap",  {31'd0, day_wrap},   32'd0);
        @(negedge clock_in) reset = 1'b0;
        @(posedge clock_in);
        #1 check("ready_after_release", {31'd0, load_ready}, 32'd1);

        // Three counted seconds with latency check.
        repeat (3) timed_tick();
        repeat (3) @(negedge clock_in);
        check("upd_count_3", n_upd, 32'd3);

        // Midnight rollover.
        do_load(8'h23, 8'h59, 8'h58, 1'b1);
        slow_pulse(1'b1);
        slow_pulse(1'b1);

        // Rejected loads leave the count alone.
        do_load(8'h00, 8'h6A, 8'h00, 1'b0);
        do_load(8'h24, 8'h00, 8'h00, 1'b0);
        repeat (3) @(negedge clock_in);
        check_count("after_bad_loads");

        // Load collides with a tick: tick first, load the following cycle.
        push_tick();
        @(negedge clock_in) slow_clk = 1'b1;
        @(posedge clock_in);
        @(posedge clock_in);
        @(negedge clock_in);
        check("ready_low_in_tick", {31'd0, load_ready}, 32'd0);
        do_load(8'h10, 8'h20, 8'h30, 1'b1);
        repeat (3) @(negedge clock_in);
        slow_clk = 1'b0;
        repeat (5) @(negedge clock_in);
        check_count("load_wins");

        // Frozen count, no burst on resume.
        run = 1'b0;
        repeat (5) slow_pulse(1'b0);
        @(negedge clock_in) run = 1'b1;
        repeat (5) @(negedge clock_in);
        check_count("frozen");
        slow_pulse(1'b1);
        check_count("resume_plus_one");

        // Asynchronous reset mid-count.
        do_load(8'h12, 8'h34, 8'h56, 1'b1);
        repeat (3) @(negedge clock_in);
        @(posedge clock_in);
        #2 reset = 1'b1;
        m_h = 0; m_m = 0; m_s = 0;
        #1 check_count("async_reset");
        check("async_reset_pm", {31'd0, pm_flag}, 32'd0);
        repeat (3) @(negedge clock_in);
        reset = 1'b0;
        repeat (2) @(negedge clock_in);

        // Afternoon hour, and the 11:59:59 -> 12:00:00 crossing.
        do_load(8'h13, 8'h05, 8'h00, 1'b1);
        do_load(8'h11, 8'h59, 8'h59, 1'b1);
        slow_pulse(1'b1);

        repeat (5) @(negedge clock_in);
        check("queue_empty", q_exp.size(), 32'd0);
        check("errors_seen", exp_err, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
